// File: rtl/fluxo_de_dados_genius_param_pkg.sv
// Shared definitions for the Genius datapath: level limits, stored button
// sequences (button index per step) and playback state encoding.
package fluxo_de_dados_genius_param_pkg;

  localparam int unsigned SEQ_BANKS = 2;
  localparam int unsigned SEQ_LEN   = 16;

  typedef enum logic [1:0] {
    EST_IDLE = 2'd0,
    EST_ON   = 2'd1,
    EST_OFF  = 2'd2,
    EST_FIM  = 2'd3
  } estado_leds_e;

  // Each entry is the lit button index; the one-hot word is built per instance width.
  localparam logic [1:0] SEQ_IDX [SEQ_BANKS][SEQ_LEN] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3,
      2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0},
    '{2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2,
      2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1}
  };

  function automatic int unsigned nivel_limite(input logic [1:0] dif,
                                               input int unsigned depth);
    return ((32'(dif) + 32'd1) * depth) / 32'd4 - 32'd1;
  endfunction

  function automatic int unsigned seq_botao(input int unsigned bank,
                                            input int unsigned addr,
                                            input int unsigned nbot);
    return 32'(SEQ_IDX[bank % SEQ_BANKS][addr % SEQ_LEN]) % nbot;
  endfunction

endpackage

// File: rtl/fluxo_de_dados_genius_param_if.sv
// Control/status bundle between the Genius control unit (master) and the
// parametrised datapath (slave).
interface fluxo_de_dados_genius_param_if #(
  parameter int N_BOTOES = 4,
  parameter int DEPTH    = 16,
  parameter int NBANK    = 2,
  parameter int SCORE_W  = 5
);
  localparam int LVL_W  = $clog2(DEPTH);
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic [N_BOTOES-1:0] botoes;
  logic                zera_nivel, conta_nivel;
  logic                zera_jogada, conta_jogada;
  logic                zera_score, conta_score;
  logic                zeraR, registraR;
  logic [1:0]          dificuldade;
  logic [BANK_W-1:0]   banco;
  logic                zera_timeout, conta_timeout;
  logic                inicia_leds;

  logic                jogada_igual_memoria, endereco_igual_limite, ultimo_nivel;
  logic                fez_jogada, jogada_invalida;
  logic                deu_timeout, meio_timeout;
  logic [N_BOTOES-1:0] db_jogada, db_memoria;
  logic [LVL_W-1:0]    db_nivel;
  logic [SCORE_W-1:0]  score;
  logic [N_BOTOES-1:0] leds;
  logic                fim_leds;

  modport master (
    output botoes, zera_nivel, conta_nivel, zera_jogada, conta_jogada,
           zera_score, conta_score, zeraR, registraR, dificuldade, banco,
           zera_timeout, conta_timeout, inicia_leds,
    input  jogada_igual_memoria, endereco_igual_limite, ultimo_nivel,
           fez_jogada, jogada_invalida, deu_timeout, meio_timeout,
           db_jogada, db_memoria, db_nivel, score, leds, fim_leds
  );

  modport slave (
    input  botoes, zera_nivel, conta_nivel, zera_jogada, conta_jogada,
           zera_score, conta_score, zeraR, registraR, dificuldade, banco,
           zera_timeout, conta_timeout, inicia_leds,
    output jogada_igual_memoria, endereco_igual_limite, ultimo_nivel,
           fez_jogada, jogada_invalida, deu_timeout, meio_timeout,
           db_jogada, db_memoria, db_nivel, score, leds, fim_leds
  );
endinterface

// File: rtl/fluxo_de_dados_genius_param_sequenciador_leds.sv
// LED playback sequencer: shows steps 0..nivel of the selected bank, each for
// T_LED_ON cycles followed by a T_LED_OFF gap, then pulses o_fim.
//   state | meaning
//   IDLE  | waiting for i_inicia; leds dark
//   ON    | showing step r_idx; timer counts the on-time down
//   OFF   | gap after step r_idx; at terminal count go to next step or FIM
//   FIM   | one-cycle end pulse, back to IDLE
module fluxo_de_dados_genius_param_sequenciador_leds
  import fluxo_de_dados_genius_param_pkg::*;
#(
  parameter int N_BOTOES  = 4,
  parameter int LVL_W     = 4,
  parameter int BANK_W    = 1,
  parameter int T_LED_ON  = 1000,
  parameter int T_LED_OFF = 250
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_inicia,
  input  logic [BANK_W-1:0]   i_banco,
  input  logic [LVL_W-1:0]    i_nivel,
  output logic [N_BOTOES-1:0] o_leds,
  output logic                o_fim
);
  localparam int TMR_W = $clog2(((T_LED_ON > T_LED_OFF) ? T_LED_ON : T_LED_OFF) + 1);
  localparam logic [TMR_W-1:0] TMR_ON  = TMR_W'(T_LED_ON - 1);
  localparam logic [TMR_W-1:0] TMR_OFF = TMR_W'(T_LED_OFF - 1);
  localparam logic [1:0] S_IDLE = EST_IDLE;
  localparam logic [1:0] S_ON   = EST_ON;
  localparam logic [1:0] S_OFF  = EST_OFF;
  localparam logic [1:0] S_FIM  = EST_FIM;

  logic [1:0]          r_estado, w_estado_prox;
  logic [TMR_W-1:0]    r_tmr, w_tmr_prox;
  logic [LVL_W-1:0]    r_idx, w_idx_prox;
  logic [N_BOTOES-1:0] r_leds, w_palavra;

  always_comb begin
    w_estado_prox = r_estado;
    w_tmr_prox    = r_tmr;
    w_idx_prox    = r_idx;
    case (r_estado)
      S_IDLE: begin
        if (i_inicia) begin
          w_estado_prox = S_ON;
          w_tmr_prox    = TMR_ON;
          w_idx_prox    = '0;
        end
      end
      S_ON: begin
        if (r_tmr == '0) begin
          w_estado_prox = S_OFF;
          w_tmr_prox    = TMR_OFF;
        end else begin
          w_tmr_prox = r_tmr - TMR_W'(1);
        end
      end
      S_OFF: begin
        if (r_tmr == '0) begin
          if (r_idx < i_nivel) begin
            w_estado_prox = S_ON;
            w_tmr_prox    = TMR_ON;
            w_idx_prox    = r_idx + LVL_W'(1);
          end else begin
            w_estado_prox = S_FIM;
          end
        end else begin
          w_tmr_prox = r_tmr - TMR_W'(1);
        end
      end
      default: w_estado_prox = S_IDLE;
    endcase
    // Second ROM read port, addressed by the step about to be shown.
    w_palavra = N_BOTOES'(1) << seq_botao(32'(i_banco), 32'(w_idx_prox), N_BOTOES);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado <= S_IDLE;
      r_tmr    <= '0;
      r_idx    <= '0;
      r_leds   <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_tmr    <= w_tmr_prox;
      r_idx    <= w_idx_prox;
      r_leds   <= (w_estado_prox == S_ON) ? w_palavra : '0;
    end
  end

  assign o_leds = r_leds;
  assign o_fim  = (r_estado == S_FIM);

endmodule

// File: rtl/fluxo_de_dados_genius_param.sv
// Parametrised Genius datapath: level/address/score counters, play register,
// sequence ROM, timeout and LED playback (sequencer built only with PLAYBACK_EN).
module fluxo_de_dados_genius_param
  import fluxo_de_dados_genius_param_pkg::*;
#(
  parameter int N_BOTOES  = 4,
  parameter int DEPTH     = 16,
  parameter int NBANK     = 2,
  parameter int SCORE_W   = 5,
  parameter int TIMEOUT   = 5000
`ifdef PLAYBACK_EN
  ,
  parameter int T_LED_ON  = 1000,
  parameter int T_LED_OFF = 250
`endif
) (
  input logic i_clock,
  input logic i_reset,
  fluxo_de_dados_genius_param_if.slave bus
);
  localparam int LVL_W  = $clog2(DEPTH);
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT);
  localparam logic [LVL_W-1:0]   NIVEL_MAX = LVL_W'(DEPTH - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [TMO_W-1:0]   TMO_FIM   = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_MEIO  = TMO_W'(TIMEOUT / 2);

  logic [LVL_W-1:0]    r_nivel, r_endereco;
  logic [SCORE_W-1:0]  r_score;
  logic [N_BOTOES-1:0] r_jogada, r_memoria, w_palavra;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_or_ant, w_or;

  assign w_or      = |bus.botoes;
  assign w_palavra = N_BOTOES'(1) << seq_botao(32'(bus.banco), 32'(r_endereco), N_BOTOES);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_nivel    <= '0;
      r_endereco <= '0;
      r_score    <= '0;
      r_jogada   <= '0;
      r_memoria  <= '0;
      r_tmo      <= '0;
      r_or_ant   <= 1'b0;
    end else begin
      if (bus.zera_nivel)                               r_nivel <= '0;
      else if (bus.conta_nivel && r_nivel != NIVEL_MAX) r_nivel <= r_nivel + LVL_W'(1);

      // Address is DEPTH wide in a power-of-two register, so it wraps naturally.
      if (bus.zera_jogada)       r_endereco <= '0;
      else if (bus.conta_jogada) r_endereco <= r_endereco + LVL_W'(1);

      if (bus.zera_score)                               r_score <= '0;
      else if (bus.conta_score && r_score != SCORE_MAX) r_score <= r_score + SCORE_W'(1);

      if (bus.zeraR)          r_jogada <= '0;
      else if (bus.registraR) r_jogada <= bus.botoes;

      if (bus.zera_timeout)                           r_tmo <= '0;
      else if (bus.conta_timeout && r_tmo != TMO_FIM) r_tmo <= r_tmo + TMO_W'(1);

      r_memoria <= w_palavra;
      r_or_ant  <= w_or;
    end
  end

  assign bus.db_nivel              = r_nivel;
  assign bus.db_jogada             = r_jogada;
  assign bus.db_memoria            = r_memoria;
  assign bus.score                 = r_score;
  assign bus.jogada_igual_memoria  = (r_jogada == r_memoria);
  assign bus.endereco_igual_limite = (r_endereco == r_nivel);
  assign bus.ultimo_nivel          = (32'(r_nivel) == nivel_limite(bus.dificuldade, DEPTH));
  assign bus.fez_jogada            = w_or & ~r_or_ant;
  assign bus.jogada_invalida       = ($countones(r_jogada) != 1);
  assign bus.deu_timeout           = (r_tmo == TMO_FIM);
  assign bus.meio_timeout          = (r_tmo >= TMO_MEIO);

`ifdef PLAYBACK_EN
  logic [N_BOTOES-1:0] w_leds;
  logic                w_fim;

  fluxo_de_dados_genius_param_sequenciador_leds #(
    .N_BOTOES (N_BOTOES),
    .LVL_W    (LVL_W),
    .BANK_W   (BANK_W),
    .T_LED_ON (T_LED_ON),
    .T_LED_OFF(T_LED_OFF)
  ) u_sequenciador (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inicia(bus.inicia_leds),
    .i_banco (bus.banco),
    .i_nivel (r_nivel),
    .o_leds  (w_leds),
    .o_fim   (w_fim)
  );

  assign bus.leds     = w_leds;
  assign bus.fim_leds = w_fim;
`else
  logic r_fim;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_fim <= 1'b0;
    else         r_fim <= bus.inicia_leds;
  end

  assign bus.leds     = '0;
  assign bus.fim_leds = r_fim;
`endif

endmodule

// File: tb/tb_fluxo_de_dados_genius_param.sv
module tb_fluxo_de_dados_genius_param;
  localparam int N       = 4;
  localparam int DEPTH   = 16;
  localparam int NBANK   = 2;
  localparam int SCORE_W = 5;
  localparam int TIMEOUT = 5000;
  localparam int T_ON    = 1000;
  localparam int T_OFF   = 250;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fluxo_de_dados_genius_param_if #(.N_BOTOES(N), .DEPTH(DEPTH), .NBANK(NBANK), .SCORE_W(SCORE_W)) bus ();

  fluxo_de_dados_genius_param #(
    .N_BOTOES(N), .DEPTH(DEPTH), .NBANK(NBANK), .SCORE_W(SCORE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // Independent copy of the stored sequences (button index per step).
  int ref_seq [2][16] = '{
    '{0, 1, 2, 3, 2, 1, 0, 3, 1, 2, 3, 0, 3, 1, 2, 0},
    '{3, 2, 1, 0, 1, 3, 0, 2, 2, 0, 3, 1, 0, 2, 3, 1}
  };

  typedef struct {
    int igual, end_lim, ultimo, fez, inval, deu, meio;
    int jog, mem, nivel, score, leds, fim;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_nivel, m_end, m_score, m_tmo, m_jog, m_mem, m_prev_or;
  int pb_q[$];
  int pb_ativo, pb_leds, pb_fim;

  function automatic int word(int b, int a);
    return 1 << ref_seq[b % 2][a % 16];
  endfunction

  function automatic int popc(int v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    int lim;
    lim       = (int'(bus.dificuldade) + 1) * DEPTH / 4 - 1;
    e.igual   = (m_jog == m_mem);
    e.end_lim = (m_end == m_nivel);
    e.ultimo  = (m_nivel == lim);
    e.fez     = (bus.botoes != 0) && (m_prev_or == 0);
    e.inval   = (popc(m_jog) != 1);
    e.deu     = (m_tmo == TIMEOUT - 1);
    e.meio    = (m_tmo >= TIMEOUT / 2);
    e.jog     = m_jog;
    e.mem     = m_mem;
    e.nivel   = m_nivel;
    e.score   = m_score;
    e.leds    = pb_leds;
    e.fim     = pb_fim;
    sb_q.push_back(e);
  endfunction

  function automatic void model_edge();
    int b;
    if (rst) begin
      m_nivel = 0; m_end = 0; m_score = 0; m_tmo = 0; m_jog = 0; m_mem = 0; m_prev_or = 0;
      pb_q.delete(); pb_ativo = 0; pb_leds = 0; pb_fim = 0;
      return;
    end
    b = int'(bus.banco);
`ifdef PLAYBACK_EN
    if (pb_ativo == 0 && bus.inicia_leds) begin
      for (int s = 0; s <= m_nivel; s++) begin
        for (int k = 0; k < T_ON; k++)  pb_q.push_back(word(b, s));
        for (int k = 0; k < T_OFF; k++) pb_q.push_back(0);
      end
      pb_q.push_back(-1);
    end
    if (pb_q.size() > 0) begin
      int x;
      x = pb_q.pop_front();
      pb_ativo = 1;
      pb_leds  = (x < 0) ? 0 : x;
      pb_fim   = (x < 0);
    end else begin
      pb_ativo = 0; pb_leds = 0; pb_fim = 0;
    end
`else
    pb_leds = 0;
    pb_fim  = bus.inicia_leds;
`endif
    m_mem = word(b, m_end);
    if (bus.zera_nivel)       m_nivel = 0;
    else if (bus.conta_nivel) m_nivel = (m_nivel < DEPTH - 1) ? m_nivel + 1 : m_nivel;
    if (bus.zera_jogada)       m_end = 0;
    else if (bus.conta_jogada) m_end = (m_end + 1) % DEPTH;
    if (bus.zera_score)       m_score = 0;
    else if (bus.conta_score) m_score = (m_score < (1 << SCORE_W) - 1) ? m_score + 1 : m_score;
    if (bus.zeraR)          m_jog = 0;
    else if (bus.registraR) m_jog = int'(bus.botoes);
    if (bus.zera_timeout)       m_tmo = 0;
    else if (bus.conta_timeout) m_tmo = (m_tmo < TIMEOUT - 1) ? m_tmo + 1 : m_tmo;
    m_prev_or = (bus.botoes != 0);
  endfunction

  task automatic cycle();
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle_inputs();
    bus.botoes = '0;
    bus.zera_nivel = 0; bus.conta_nivel = 0;
    bus.zera_jogada = 0; bus.conta_jogada = 0;
    bus.zera_score = 0; bus.conta_score = 0;
    bus.zeraR = 0; bus.registraR = 0;
    bus.zera_timeout = 0; bus.conta_timeout = 0;
    bus.inicia_leds = 0;
  endtask

  // Monitor: the datapath presents a full output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("jogada_igual_memoria", int'(bus.jogada_igual_memoria), e.igual);
        chk("endereco_igual_limite", int'(bus.endereco_igual_limite), e.end_lim);
        chk("ultimo_nivel", int'(bus.ultimo_nivel), e.ultimo);
        chk("fez_jogada", int'(bus.fez_jogada), e.fez);
        chk("jogada_invalida", int'(bus.jogada_invalida), e.inval);
        chk("deu_timeout", int'(bus.deu_timeout), e.deu);
        chk("meio_timeout", int'(bus.meio_timeout), e.meio);
        chk("db_jogada", int'(bus.db_jogada), e.jog);
        chk("db_memoria", int'(bus.db_memoria), e.mem);
        chk("db_nivel", int'(bus.db_nivel), e.nivel);
        chk("score", int'(bus.score), e.score);
        chk("leds", int'(bus.leds), e.leds);
        chk("fim_leds", int'(bus.fim_leds), e.fim);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.dificuldade = 2'd0;
    bus.banco = '0;
    @(posedge clk);
    model_edge();
    #1;
    run(2);
    rst = 1'b0;
    run(2);

    // Reset in the middle of counting
    bus.conta_score = 1; bus.conta_nivel = 1; bus.conta_timeout = 1;
    run(3);
    bus.conta_nivel = 0;
    run(2);
    bus.conta_score = 0; bus.conta_timeout = 0;
    bus.botoes = 4'b0010; bus.registraR = 1;
    cycle();
    bus.botoes = '0; bus.registraR = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(2);

    // Difficulty limit and level saturation
    bus.dificuldade = 2'd1;
    bus.conta_nivel = 1;
    run(7);
    bus.conta_nivel = 0;
    run(2);
    bus.conta_nivel = 1;
    run(10);
    bus.conta_nivel = 0;
    for (int d = 0; d < 4; d++) begin
      bus.dificuldade = 2'(d);
      cycle();
    end
    bus.zera_nivel = 1; bus.conta_nivel = 1;
    cycle();
    bus.zera_nivel = 0; bus.conta_nivel = 0;
    run(1);

    // Held press, registered word matching the sequence (bank 0, addr 2 = 0100)
    bus.banco = 1'b0;
    bus.zera_jogada = 1;
    cycle();
    bus.zera_jogada = 0; bus.conta_jogada = 1;
    run(2);
    bus.conta_jogada = 0;
    run(1);
    bus.botoes = 4'b0100;
    run(9);
    bus.registraR = 1;
    cycle();
    bus.registraR = 0; bus.botoes = '0;
    run(3);

    // Multi-press is invalid, cleared register stays invalid
    bus.botoes = 4'b0110; bus.registraR = 1;
    cycle();
    bus.registraR = 0; bus.botoes = '0;
    run(2);
    bus.zeraR = 1;
    cycle();
    bus.zeraR = 0;
    run(2);

    // Timeout: half mark, terminal hold, clear wins over count
    bus.zera_timeout = 1;
    cycle();
    bus.zera_timeout = 0; bus.conta_timeout = 1;
    run(TIMEOUT + 5);
    bus.conta_timeout = 0;
    run(3);
    bus.conta_timeout = 1; bus.zera_timeout = 1;
    cycle();
    bus.conta_timeout = 0; bus.zera_timeout = 0;
    run(2);

`ifdef PLAYBACK_EN
    bus.zera_nivel = 1;
    cycle();
    bus.zera_nivel = 0; bus.conta_nivel = 1;
    run(2);
    bus.conta_nivel = 0; bus.banco = 1'b0;
    run(1);
    bus.inicia_leds = 1;
    cycle();
    bus.inicia_leds = 0;
    run(600);
    bus.inicia_leds = 1;
    cycle();
    bus.inicia_leds = 0;
    run(3300);
    bus.banco = 1'b1; bus.inicia_leds = 1;
    cycle();
    bus.inicia_leds = 0;
    run(500);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(5);
`else
    bus.inicia_leds = 1;
    cycle();
    bus.inicia_leds = 0;
    run(3);
    bus.inicia_leds = 1;
    run(2);
    bus.inicia_leds = 0;
    run(3);
`endif

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(99) == 0);
      bus.zera_nivel    = ($urandom_range(15) == 0);
      bus.conta_nivel   = $urandom_range(1);
      bus.zera_jogada   = ($urandom_range(15) == 0);
      bus.conta_jogada  = $urandom_range(1);
      bus.zera_score    = ($urandom_range(31) == 0);
      bus.conta_score   = $urandom_range(1);
      bus.zeraR         = ($urandom_range(7) == 0);
      bus.registraR     = ($urandom_range(3) == 0);
      bus.zera_timeout  = ($urandom_range(63) == 0);
      bus.conta_timeout = ($urandom_range(3) != 0);
      bus.dificuldade   = 2'($urandom_range(3));
      bus.banco         = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) bus.botoes = 4'($urandom_range(15));
`ifdef PLAYBACK_EN
      bus.inicia_leds = 0;
`else
      bus.inicia_leds = ($urandom_range(7) == 0);
`endif
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    run(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
